// File: rtl/fifo_async_write_ptr_if.sv
// rtl/fifo_async_write_ptr_if.sv - write-side pointer/flag bundle of the async FIFO
interface fifo_async_write_ptr_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int PTR_WIDTH  = ADDR_WIDTH + 1
);
   logic                  write_in;
   logic                  clr_ovf_in;
   logic [PTR_WIDTH-1:0]  rptr_g_sync_in;
   logic [ADDR_WIDTH-1:0] waddr_out;
   logic                  wen_out;
   logic [PTR_WIDTH-1:0]  wptr_b_out;
   logic [PTR_WIDTH-1:0]  wptr_g_out;
   logic                  full_out;
   logic                  almost_full_out;
   logic [PTR_WIDTH-1:0]  wlevel_out;
   logic                  overflow_out;

   modport master (
      output write_in, clr_ovf_in, rptr_g_sync_in,
      input  waddr_out, wen_out, wptr_b_out, wptr_g_out,
             full_out, almost_full_out, wlevel_out, overflow_out
   );

   modport slave (
      input  write_in, clr_ovf_in, rptr_g_sync_in,
      output waddr_out, wen_out, wptr_b_out, wptr_g_out,
             full_out, almost_full_out, wlevel_out, overflow_out
   );
endinterface

// File: rtl/fifo_async_write_ptr.sv
// rtl/fifo_async_write_ptr.sv - async FIFO write-domain pointers, full/almost-full/level/overflow
module gray2bin #(
   parameter int W = 4
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end
endmodule

module fifo_async_write_ptr #(
   parameter int ADDR_WIDTH = 3,
   parameter int PTR_WIDTH  = ADDR_WIDTH + 1,
   parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
   input  logic                 write_clk,
   input  logic                 rst_in,
   fifo_async_write_ptr_if.slave bus
);
   localparam logic [PTR_WIDTH-1:0] AF_LIMIT = PTR_WIDTH'(AF_THRESH);

   logic                 accept;
   logic [PTR_WIDTH-1:0] wptr_b_next;
   logic [PTR_WIDTH-1:0] wptr_g_next;
   logic [PTR_WIDTH-1:0] rptr_b_sync;
   logic [PTR_WIDTH-1:0] level_next;
   logic                 full_next;
   logic                 almost_full_next;

   gray2bin #(.W(PTR_WIDTH)) u_rptr_g2b (
      .gray (bus.rptr_g_sync_in),
      .bin  (rptr_b_sync)
   );

   assign accept        = bus.write_in & ~bus.full_out;
   assign bus.wen_out   = accept;
   assign bus.waddr_out = bus.wptr_b_out[ADDR_WIDTH-1:0];

   assign wptr_b_next = bus.wptr_b_out + PTR_WIDTH'(accept);
   assign wptr_g_next = (wptr_b_next >> 1) ^ wptr_b_next;

   // Full when the write pointer has lapped the read pointer by exactly one depth.
   assign full_next = (wptr_g_next == {~bus.rptr_g_sync_in[PTR_WIDTH-1:PTR_WIDTH-2],
                                       bus.rptr_g_sync_in[PTR_WIDTH-3:0]});
   assign level_next       = wptr_b_next - rptr_b_sync;
   assign almost_full_next = (level_next >= AF_LIMIT);

   always_ff @(posedge write_clk) begin
      if (rst_in) begin
         bus.wptr_b_out      <= '0;
         bus.wptr_g_out      <= '0;
         bus.full_out        <= 1'b0;
         bus.almost_full_out <= 1'b0;
         bus.wlevel_out      <= '0;
         bus.overflow_out    <= 1'b0;
      end else begin
         bus.wptr_b_out      <= wptr_b_next;
         bus.wptr_g_out      <= wptr_g_next;
         bus.full_out        <= full_next;
         bus.almost_full_out <= almost_full_next;
         bus.wlevel_out      <= level_next;
         // A rejected write sets the flag even if a clear arrives in the same cycle.
         if (bus.write_in & bus.full_out)
            bus.overflow_out <= 1'b1;
         else if (bus.clr_ovf_in)
            bus.overflow_out <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fifo_async_write_ptr.sv
// tb/tb_fifo_async_write_ptr.sv - directed self-checking bench for fifo_async_write_ptr
module tb_fifo_async_write_ptr;
   logic write_clk = 1'b0;
   logic rst_in;
   int   checks   = 0;
   int   failures = 0;

   fifo_async_write_ptr_if #(.ADDR_WIDTH(3), .PTR_WIDTH(4)) bus ();

   fifo_async_write_ptr #(.ADDR_WIDTH(3), .PTR_WIDTH(4), .AF_THRESH(6)) dut (
      .write_clk (write_clk),
      .rst_in    (rst_in),
      .bus       (bus)
   );

   always #5 write_clk = ~write_clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge write_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      expect_eq({tag, "_wptr_b"}, 32'(bus.wptr_b_out), 0);
      expect_eq({tag, "_wptr_g"}, 32'(bus.wptr_g_out), 0);
      expect_eq({tag, "_full"}, 32'(bus.full_out), 0);
      expect_eq({tag, "_afull"}, 32'(bus.almost_full_out), 0);
      expect_eq({tag, "_level"}, 32'(bus.wlevel_out), 0);
      expect_eq({tag, "_ovf"}, 32'(bus.overflow_out), 0);
      expect_eq({tag, "_waddr"}, 32'(bus.waddr_out), 0);
   endtask

   initial begin
      rst_in             = 1'b1;
      bus.write_in       = 1'b1;
      bus.clr_ovf_in     = 1'b0;
      bus.rptr_g_sync_in = 4'b0000;

      // Reset held with a write request
      tick();
      tick();
      check_all_zero("reset");

      // Fill: eight back-to-back writes, read side parked at 0
      rst_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         expect_eq($sformatf("fill_wen_%0d", i), 32'(bus.wen_out), 1);
         expect_eq($sformatf("fill_waddr_%0d", i), 32'(bus.waddr_out), i - 1);
         tick();
         expect_eq($sformatf("fill_wptr_%0d", i), 32'(bus.wptr_b_out), i);
         expect_eq($sformatf("fill_level_%0d", i), 32'(bus.wlevel_out), i);
         expect_eq($sformatf("fill_afull_%0d", i), 32'(bus.almost_full_out), (i >= 6) ? 1 : 0);
         expect_eq($sformatf("fill_full_%0d", i), 32'(bus.full_out), (i == 8) ? 1 : 0);
      end
      expect_eq("fill_wptr_g", 32'(bus.wptr_g_out), 32'h0000000c);

      // Overflow set, set-over-clear priority, then clear
      expect_eq("ovf_wen", 32'(bus.wen_out), 0);
      tick();
      expect_eq("ovf_wptr", 32'(bus.wptr_b_out), 8);
      expect_eq("ovf_set", 32'(bus.overflow_out), 1);
      expect_eq("ovf_full_hold", 32'(bus.full_out), 1);
      bus.clr_ovf_in = 1'b1;
      tick();
      expect_eq("ovf_set_priority", 32'(bus.overflow_out), 1);
      bus.write_in = 1'b0;
      tick();
      expect_eq("ovf_cleared", 32'(bus.overflow_out), 0);
      bus.clr_ovf_in = 1'b0;

      // Drain: read side reaches 8 (Gray 1100)
      bus.rptr_g_sync_in = 4'b1100;
      tick();
      expect_eq("drain_full", 32'(bus.full_out), 0);
      expect_eq("drain_level", 32'(bus.wlevel_out), 0);
      expect_eq("drain_afull", 32'(bus.almost_full_out), 0);

      // Wrap: eight more writes, pointer goes 9..15 then 0
      bus.write_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         expect_eq($sformatf("wrap_wptr_%0d", i), 32'(bus.wptr_b_out), (8 + i) % 16);
         expect_eq($sformatf("wrap_level_%0d", i), 32'(bus.wlevel_out), i);
         expect_eq($sformatf("wrap_full_%0d", i), 32'(bus.full_out), (i == 8) ? 1 : 0);
      end

      // Simultaneous: read to 9 gives level 7, then write plus read to 10
      bus.write_in       = 1'b0;
      bus.rptr_g_sync_in = 4'b1101;
      tick();
      expect_eq("sim_pre_level", 32'(bus.wlevel_out), 7);
      expect_eq("sim_pre_full", 32'(bus.full_out), 0);
      bus.write_in       = 1'b1;
      bus.rptr_g_sync_in = 4'b1111;
      tick();
      expect_eq("sim_level", 32'(bus.wlevel_out), 7);
      expect_eq("sim_full", 32'(bus.full_out), 0);
      expect_eq("sim_afull", 32'(bus.almost_full_out), 1);
      expect_eq("sim_wptr_b", 32'(bus.wptr_b_out), 1);
      expect_eq("sim_wptr_g", 32'(bus.wptr_g_out), 1);

      // Reset mid-burst at level 5
      bus.write_in = 1'b0;
      rst_in       = 1'b1;
      tick();
      rst_in             = 1'b0;
      bus.rptr_g_sync_in = 4'b0000;
      bus.write_in       = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      expect_eq("mid_level5", 32'(bus.wlevel_out), 5);
      rst_in = 1'b1;
      tick();
      check_all_zero("mid_reset");
      rst_in = 1'b0;
      expect_eq("resume_wen", 32'(bus.wen_out), 1);
      expect_eq("resume_waddr", 32'(bus.waddr_out), 0);
      tick();
      expect_eq("resume_wptr", 32'(bus.wptr_b_out), 1);
      expect_eq("resume_level", 32'(bus.wlevel_out), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_async_write_ptr.md
Name: fifo_async_write_ptr

Overview:
Write-side pointer and flag logic of the async FIFO, in the write clock domain. It advances the binary write pointer on accepted writes and drives the memory write address and enable. It also publishes the Gray write pointer to the synchroniser toward the read side. It derives full, almost-full, fill level and a sticky overflow flag from the read Gray pointer after it has been synchronised into this domain.

Parameters:
ADDR_WIDTH, 3, memory address width; FIFO depth = 2^ADDR_WIDTH
PTR_WIDTH, ADDR_WIDTH+1, pointer width (address bits plus one wrap bit); must equal ADDR_WIDTH+1
AF_THRESH, 2^ADDR_WIDTH-2, fill level at or above which almost_full_out asserts; legal range 1..2^ADDR_WIDTH

Ports:
write_clk  in  1  write-domain clock; all state updates on its rising edge
rst_in  in  1  synchronous, active-high reset
write_in  in  1  write request for this cycle
clr_ovf_in  in  1  clears the sticky overflow flag
rptr_g_sync_in  in  PTR_WIDTH  read Gray pointer, already two-flop synchronised into write_clk
waddr_out  out  ADDR_WIDTH  memory write address = wptr_b_out[ADDR_WIDTH-1:0]
wen_out  out  1  memory write enable = write_in & ~full_out (combinational)
wptr_b_out  out  PTR_WIDTH  registered binary write pointer
wptr_g_out  out  PTR_WIDTH  registered Gray write pointer, to the synchroniser
full_out  out  1  registered full flag
almost_full_out  out  1  registered almost-full flag
wlevel_out  out  PTR_WIDTH  registered fill level as seen from the write side, 0..2^ADDR_WIDTH
overflow_out  out  1  sticky flag: a write was attempted while full

Behaviour:
- One clock (write_clk); reset synchronous, active-high (rst_in), sampled on the rising edge.
- Reset values: wptr_b_out=0, wptr_g_out=0, full_out=0, almost_full_out=0, wlevel_out=0, overflow_out=0. Reset overrides every other input in the same cycle, including mid-burst.
- Accept = write_in & ~full_out. wptr_b_next = wptr_b_out + accept, modulo 2^PTR_WIDTH, so it wraps from all-ones to 0.
- wptr_g_next = (wptr_b_next >> 1) ^ wptr_b_next. Both pointers are registered from their next values, so the Gray output changes at most one bit per cycle.
- rptr_b_sync = Gray-to-binary conversion of rptr_g_sync_in (combinational; reuse the existing gray2bin module).
- full_next = (wptr_g_next == {~rptr_g_sync_in[PTR_WIDTH-1:PTR_WIDTH-2], rptr_g_sync_in[PTR_WIDTH-3:0]}).
- level_next = wptr_b_next - rptr_b_sync, computed in PTR_WIDTH bits modulo 2^PTR_WIDTH.
- almost_full_next = (level_next >= AF_THRESH).
- full_out, almost_full_out and wlevel_out are registered from their next values on every non-reset edge.
- Latency: a write accepted in cycle N updates the pointers and flags at the end of cycle N. full_out is therefore valid for the very next write attempt.
- Flags are pessimistic. A read on the other side lowers full_out only after the synchroniser delay (≥2 write_clk edges plus the read-side register). full_out must never deassert while the FIFO is actually full.
- Write while full: the pointer holds, wen_out=0, and overflow_out is set at the next edge.
- overflow_out: if a write is attempted while full, overflow_out is set regardless of clr_ovf_in (set has priority). Otherwise, if clr_ovf_in=1, overflow_out is cleared. Otherwise it holds.
- If rptr_g_sync_in changes in the same cycle as an accepted write, both effects appear at one edge. The level changes by +1 minus the read advance.
- No FSM. The state is the pointer registers, the flag registers and the overflow bit.

Test Plan:
(All cases use ADDR_WIDTH=3, PTR_WIDTH=4, AF_THRESH=6.)
1. Reset: rst_in=1 for 2 cycles with write_in=1 -> all outputs 0 and the pointer does not advance.
2. Fill: rptr_g_sync_in=0, 8 back-to-back writes ->
   - wptr_b_out steps 1..8 and wlevel_out steps 1..8;
   - almost_full_out rises at the edge of the 6th write;
   - full_out rises at the edge of the 8th write, with wptr_g_out=4'b1100.
3. Overflow: from full, write_in=1 for 1 cycle -> wen_out=0, wptr_b_out stays 8, overflow_out=1. Then clr_ovf_in=1 together with write_in=1 -> overflow_out stays 1. Then clr_ovf_in=1 alone -> overflow_out=0.
4. Drain and wrap:
   - set rptr_g_sync_in=4'b1100 (read side at 8) -> full_out=0 and wlevel_out=0 one edge later;
   - 8 further writes -> wptr_b_out wraps 15->0, and full_out=1 when wptr_b_out=0.
5. Simultaneous events: at level 7, one write plus a rptr_g_sync_in advance by 1 in the same cycle -> wlevel_out stays 7 and full_out stays 0.
6. Reset mid-burst: rst_in=1 during writes at level 5 -> next edge all outputs 0, and writing resumes at address 0.
